exec_sequencer: RTL and testbench

//  Execute-stage sequencer feeding the combinational ALU. Accepts one decoded RV32I instruction per handshake and

---
 rtl/exec_sequencer_pkg.sv | 48 ++++
 rtl/exec_sequencer_if.sv | 48 ++++
 rtl/exec_sequencer_decode.sv | 76 +++++++
 rtl/exec_sequencer.sv | 119 +++++++++++
 tb/tb_exec_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared RV32I opcode constants, ALU op encodings, FSM/instruction-kind enums
// and small decode helpers for the execute-stage sequencer.
package exec_sequencer_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {S_IDLE, S_EX1, S_EX2, S_DONE} state_e;

    typedef enum logic [2:0] {K_ALU, K_BRANCH, K_JAL, K_JALR, K_ILLEGAL} kind_e;

    // Shift amounts are five bits; the rest of the operand must never reach the ALU.
    function automatic logic [31:0] shamt_mask(input logic [2:0] f3, input logic [31:0] b);
        return (f3[1:0] == 2'b01) ? {27'b0, b[4:0]} : b;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic lt, input logic carry);
        case (f3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return carry;
            3'b111:  return !carry;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction-in, ALU-side and result-out signal bundle of the execute sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface exec_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [31:0] in_pc;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_oe;
    logic [31:0] alu_data;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_lt;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_redirect;
    logic [31:0] out_target;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, in_pc,
        input  alu_data, alu_carry, alu_zero, alu_lt, out_ready,
        output in_ready, alu_a, alu_b, alu_op, alu_oe,
        output out_valid, out_result, out_rd, out_wb_en, out_redirect, out_target, out_illegal
    );

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, in_pc,
        output alu_data, alu_carry, alu_zero, alu_lt, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, alu_oe,
        input  out_valid, out_result, out_rd, out_wb_en, out_redirect, out_target, out_illegal
    );

endinterface

// File: rtl/exec_sequencer_decode.sv
// Combinational decode: opcode/funct fields -> instruction kind, first-pass ALU
// operands and op, and the first operand of the optional second (target) pass.
module exec_sequencer_decode
    import exec_sequencer_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output kind_e       kind,
    output logic [31:0] ex1_a,
    output logic [31:0] ex1_b,
    output logic [3:0]  ex1_op,
    output logic [31:0] ex2_a
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        kind   = K_ILLEGAL;
        ex1_a  = '0;
        ex1_b  = '0;
        ex1_op = ALU_ADD;
        ex2_a  = pc;
        case (opcode)
            OPC_OP: begin
                if (!funct7b5 || funct3 == 3'b000 || funct3 == 3'b101) begin
                    kind   = K_ALU;
                    ex1_a  = rs1;
                    ex1_b  = shamt_mask(funct3, rs2);
                    ex1_op = {funct7b5, funct3};
                end
            end
            OPC_OPIMM: begin
                kind   = K_ALU;
                ex1_a  = rs1;
                ex1_b  = shamt_mask(funct3, imm);
                ex1_op = {(funct3 == 3'b101) && funct7b5, funct3};
            end
            OPC_LUI: begin
                kind  = K_ALU;
                ex1_b = imm;
            end
            OPC_AUIPC: begin
                kind  = K_ALU;
                ex1_a = pc;
                ex1_b = imm;
            end
            OPC_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    kind   = K_BRANCH;
                    ex1_a  = rs1;
                    ex1_b  = rs2;
                    ex1_op = ALU_SUB;
                end
            end
            OPC_JAL: begin
                kind  = K_JAL;
                ex1_a = pc;
                ex1_b = 32'd4;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    kind  = K_JALR;
                    ex1_a = pc;
                    ex1_b = 32'd4;
                    ex2_a = rs1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: latches one instruction, runs one or two ALU passes,
// resolves branches/jumps and holds the writeback/redirect packet until popped.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC_LINK = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    exec_sequencer_if.slave   bus
);

    state_e      state, state_next;
    kind_e       kind_q, dec_kind;
    logic [2:0]  f3_q;
    logic [31:0] ex2_a_q, imm_q;
    logic [31:0] dec_a, dec_b, dec_ex2_a;
    logic [3:0]  dec_op;
    logic        two_pass;

    exec_sequencer_decode u_decode (
        .opcode   (bus.in_opcode),
        .funct3   (bus.in_funct3),
        .funct7b5 (bus.in_funct7b5),
        .rs1      (bus.in_rs1),
        .rs2      (bus.in_rs2),
        .imm      (bus.in_imm),
        .pc       (bus.in_pc),
        .kind     (dec_kind),
        .ex1_a    (dec_a),
        .ex1_b    (dec_b),
        .ex1_op   (dec_op),
        .ex2_a    (dec_ex2_a)
    );

    assign two_pass = (kind_q == K_BRANCH) || (kind_q == K_JAL) || (kind_q == K_JALR);

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.alu_oe    = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = S_EX1;
            end
            S_EX1: begin
                bus.alu_oe = 1'b1;
                state_next = two_pass ? S_EX2 : S_DONE;
            end
            S_EX2: begin
                bus.alu_oe = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q           <= K_ILLEGAL;
            f3_q             <= '0;
            ex2_a_q          <= '0;
            imm_q            <= '0;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.alu_op       <= ALU_ADD;
            bus.out_result   <= RESET_PC_LINK;
            bus.out_rd       <= '0;
            bus.out_wb_en    <= 1'b0;
            bus.out_redirect <= 1'b0;
            bus.out_target   <= '0;
            bus.out_illegal  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    kind_q     <= dec_kind;
                    f3_q       <= bus.in_funct3;
                    ex2_a_q    <= dec_ex2_a;
                    imm_q      <= bus.in_imm;
                    bus.alu_a  <= dec_a;
                    bus.alu_b  <= dec_b;
                    bus.alu_op <= dec_op;
                    bus.out_rd <= bus.in_rd;
                end
                S_EX1: begin
                    bus.out_illegal  <= (kind_q == K_ILLEGAL);
                    bus.out_redirect <= (kind_q == K_JAL) || (kind_q == K_JALR) ||
                                        ((kind_q == K_BRANCH) &&
                                         branch_taken(f3_q, bus.alu_zero, bus.alu_lt, bus.alu_carry));
                    bus.out_wb_en    <= (kind_q != K_BRANCH) && (kind_q != K_ILLEGAL) &&
                                        (bus.out_rd != 5'd0);
                    if (kind_q != K_BRANCH) bus.out_result <= bus.alu_data;
                    if (two_pass) begin
                        bus.alu_a  <= ex2_a_q;
                        bus.alu_b  <= imm_q;
                        bus.alu_op <= ALU_ADD;
                    end
                end
                S_EX2: begin
                    bus.out_target <= (kind_q == K_JALR) ? (bus.alu_data & ~32'h1) : bus.alu_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural ALU: vector table plus
// hand-written backpressure and mid-instruction reset sequences.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exec_sequencer_if bus ();

    exec_sequencer #(.RESET_PC_LINK(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RV32I ALU; carry is the unsigned borrow of a-b.
    logic [31:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            4'b0000: alu_res = bus.alu_a + bus.alu_b;
            4'b1000: alu_res = bus.alu_a - bus.alu_b;
            4'b0001: alu_res = bus.alu_a << bus.alu_b[4:0];
            4'b0010: alu_res = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            4'b0011: alu_res = {31'b0, bus.alu_a < bus.alu_b};
            4'b0100: alu_res = bus.alu_a ^ bus.alu_b;
            4'b0101: alu_res = bus.alu_a >> bus.alu_b[4:0];
            4'b1101: alu_res = 32'($signed(bus.alu_a) >>> bus.alu_b[4:0]);
            4'b0110: alu_res = bus.alu_a | bus.alu_b;
            4'b0111: alu_res = bus.alu_a & bus.alu_b;
            default: alu_res = '0;
        endcase
    end
    assign bus.alu_data  = bus.alu_oe ? alu_res : 32'h0;
    assign bus.alu_carry = bus.alu_a < bus.alu_b;
    assign bus.alu_lt    = $signed(bus.alu_a) < $signed(bus.alu_b);
    assign bus.alu_zero  = (alu_res == 32'h0);

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [31:0] rs1, rs2, imm, pc;
        int          passes;
        logic [31:0] result;
        logic        chk_result;
        logic        wb_en, redirect;
        logic [31:0] target;
        logic        illegal;
    } vec_t;

    vec_t        vecs[17];
    logic [31:0] first_alu_b;

    function automatic vec_t mkv(logic [6:0] opc, logic [2:0] f3, logic f7, logic [4:0] rd,
                                 logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                                 logic [31:0] pc, int passes, logic [31:0] res, logic chk,
                                 logic wb, logic redir, logic [31:0] tgt, logic ill);
        vec_t v;
        v.opcode = opc; v.f3 = f3; v.f7b5 = f7; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
        v.passes = passes; v.result = res; v.chk_result = chk;
        v.wb_en = wb; v.redirect = redir; v.target = tgt; v.illegal = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/in_ready"},  32'(bus.in_ready), 32'd1);
        check({tag, "/out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "/alu_oe"},    32'(bus.alu_oe), 32'd0);
        check({tag, "/alu_a"},     bus.alu_a, 32'd0);
        check({tag, "/alu_b"},     bus.alu_b, 32'd0);
        check({tag, "/alu_op"},    32'(bus.alu_op), 32'd0);
        check({tag, "/result"},    bus.out_result, 32'h0);
        check({tag, "/rd"},        32'(bus.out_rd), 32'd0);
        check({tag, "/target"},    bus.out_target, 32'd0);
        check({tag, "/flags"},     {29'b0, bus.out_wb_en, bus.out_redirect, bus.out_illegal}, 32'd0);
    endtask

    // Drives one instruction and completes the accept edge; in_* are scrambled afterwards.
    task automatic issue(input vec_t v, input string tag);
        @(negedge clk);
        bus.in_opcode   = v.opcode;
        bus.in_funct3   = v.f3;
        bus.in_funct7b5 = v.f7b5;
        bus.in_rd       = v.rd;
        bus.in_rs1      = v.rs1;
        bus.in_rs2      = v.rs2;
        bus.in_imm      = v.imm;
        bus.in_pc       = v.pc;
        bus.in_valid    = 1'b1;
        check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_rs1   = $urandom;
        bus.in_rs2   = $urandom;
        bus.in_imm   = $urandom;
        bus.in_pc    = $urandom;
        bus.in_rd    = 5'($urandom);
    endtask

    // Counts falling edges after accept until out_valid; 0 means the bound expired.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                first_alu_b = bus.alu_b;
                check({tag, "/alu_oe_ex1"}, 32'(bus.alu_oe), 32'd1);
            end
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        issue(v, tag);
        wait_valid(tag, lat);
        // Seen at the falling edge before N+2 (one pass) or N+3 (two passes).
        check({tag, "/latency"}, 32'(lat), 32'(v.passes + 1));
        check({tag, "/rd"},       32'(bus.out_rd), 32'(v.rd));
        check({tag, "/wb_en"},    32'(bus.out_wb_en), 32'(v.wb_en));
        check({tag, "/redirect"}, 32'(bus.out_redirect), 32'(v.redirect));
        check({tag, "/illegal"},  32'(bus.out_illegal), 32'(v.illegal));
        if (v.chk_result) check({tag, "/result"}, bus.out_result, v.result);
        if (v.redirect)   check({tag, "/target"}, bus.out_target, v.target);
        pop();
    endtask

    initial begin
        int   lat;
        logic saw_valid;

        vecs[0]  = mkv(OPC_OP,     3'b000, 1'b0, 5'd3,  32'd5,        32'd7,        32'h0,        32'h0,   1, 32'd12,       1, 1, 0, 32'h0,   0);
        vecs[1]  = mkv(OPC_OP,     3'b000, 1'b1, 5'd4,  32'd5,        32'd7,        32'h0,        32'h0,   1, 32'hFFFFFFFE, 1, 1, 0, 32'h0,   0);
        vecs[2]  = mkv(OPC_OPIMM,  3'b101, 1'b1, 5'd5,  32'h80000000, 32'h0,        32'h04000024, 32'h0,   1, 32'hF8000000, 1, 1, 0, 32'h0,   0);
        vecs[3]  = mkv(OPC_OPIMM,  3'b000, 1'b0, 5'd0,  32'd10,       32'h0,        32'hFFFFFFFD, 32'h0,   1, 32'd7,        1, 0, 0, 32'h0,   0);
        vecs[4]  = mkv(OPC_OP,     3'b011, 1'b0, 5'd6,  32'd1,        32'd2,        32'h0,        32'h0,   1, 32'd1,        1, 1, 0, 32'h0,   0);
        vecs[5]  = mkv(OPC_OP,     3'b100, 1'b1, 5'd7,  32'd1,        32'd2,        32'h0,        32'h0,   1, 32'h0,        0, 0, 0, 32'h0,   1);
        vecs[6]  = mkv(OPC_LUI,    3'b000, 1'b0, 5'd8,  32'hDEAD,     32'h0,        32'h12345000, 32'h0,   1, 32'h12345000, 1, 1, 0, 32'h0,   0);
        vecs[7]  = mkv(OPC_AUIPC,  3'b000, 1'b0, 5'd9,  32'h0,        32'h0,        32'h2000,     32'h1000,1, 32'h3000,     1, 1, 0, 32'h0,   0);
        vecs[8]  = mkv(OPC_BRANCH, 3'b110, 1'b0, 5'd0,  32'd1,        32'hFFFFFFFF, 32'hFFFFFFF0, 32'h100, 2, 32'h0,        0, 0, 1, 32'hF0,  0);
        vecs[9]  = mkv(OPC_BRANCH, 3'b000, 1'b0, 5'd0,  32'd3,        32'd4,        32'h8,        32'h200, 2, 32'h0,        0, 0, 0, 32'h0,   0);
        vecs[10] = mkv(OPC_BRANCH, 3'b101, 1'b0, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h20,       32'h300, 2, 32'h0,        0, 0, 1, 32'h320, 0);
        vecs[11] = mkv(OPC_JAL,    3'b000, 1'b0, 5'd1,  32'h0,        32'h0,        32'h800,      32'h400, 2, 32'h404,      1, 1, 1, 32'hC00, 0);
        vecs[12] = mkv(OPC_JALR,   3'b000, 1'b0, 5'd1,  32'h203,      32'h0,        32'h0,        32'h40,  2, 32'h44,       1, 1, 1, 32'h202, 0);
        vecs[13] = mkv(7'b0001111, 3'b000, 1'b0, 5'd2,  32'h0,        32'h0,        32'h0,        32'h0,   1, 32'h0,        0, 0, 0, 32'h0,   1);
        vecs[14] = mkv(OPC_BRANCH, 3'b010, 1'b0, 5'd0,  32'd1,        32'd1,        32'h10,       32'h0,   1, 32'h0,        0, 0, 0, 32'h0,   1);
        vecs[15] = mkv(OPC_OP,     3'b001, 1'b0, 5'd10, 32'd1,        32'h25,       32'h0,        32'h0,   1, 32'h20,       1, 1, 0, 32'h0,   0);
        vecs[16] = mkv(OPC_BRANCH, 3'b001, 1'b0, 5'd0,  32'd1,        32'd2,        32'hFFFFFFFC, 32'h80,  2, 32'h0,        0, 0, 1, 32'h7C,  0);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7b5 = 1'b0; bus.in_rd = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.in_pc = '0;
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 2) check("srai/alu_b", first_alu_b, 32'd4);
        end

        // Backpressure: packet must hold steady for five cycles with out_ready low.
        issue(vecs[0], "bp");
        wait_valid("bp", lat);
        check("bp/latency", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp/out_valid", 32'(bus.out_valid), 32'd1);
            check("bp/in_ready",  32'(bus.in_ready), 32'd0);
            check("bp/result",    bus.out_result, 32'd12);
            check("bp/rd_wb",     {26'b0, bus.out_rd, bus.out_wb_en}, {26'b0, 5'd3, 1'b1});
        end
        pop();
        check("bp/in_ready_after_pop", 32'(bus.in_ready), 32'd1);
        check("bp/out_valid_after_pop", 32'(bus.out_valid), 32'd0);

        // Reset asserted during EX2 of a BEQ discards the instruction.
        issue(vecs[9], "rst");
        @(negedge clk);
        @(negedge clk);
        check("rst/ex2_oe", 32'(bus.alu_oe), 32'd1);
        check("rst/ex2_alu_a", bus.alu_a, 32'h200);
        rst = 1'b1;
        #1;
        check_reset_state("rst");
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("rst/no_packet", 32'(saw_valid), 32'd0);
        run_vec(vecs[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
